// File: rtl/usb_cdc_regbridge_if.sv
// rtl/usb_cdc_regbridge_if.sv - CDC byte-stream handshake bundle between the CDC core and the register bridge
interface usb_cdc_regbridge_if;
    logic [7:0] out_data_i;
    logic       out_valid_i;
    logic       out_ready_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i;

    modport slave (
        input  out_data_i, out_valid_i, in_ready_i,
        output out_ready_o, in_data_o, in_valid_o
    );

    modport master (
        output out_data_i, out_valid_i, in_ready_i,
        input  out_ready_o, in_data_o, in_valid_o
    );
endinterface

// File: rtl/usb_cdc_regbridge.sv
// rtl/usb_cdc_regbridge.sv - CDC byte-stream register bridge (W/R/status commands, one response byte each)
// Optional REGBRIDGE_CHECKSUM_EN adds a 4th write byte (opcode ^ addr ^ data).
module usb_cdc_regbridge #(
    parameter int NREGS   = 8,
    parameter int TIMEOUT = 48000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    usb_cdc_regbridge_if.slave       bus,
    input  logic [7:0]               status_i,
    output logic [NREGS*8-1:0]       regs_o,
    output logic                     timeout_o
);
    localparam int         CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [8:0] NREGS_W = 9'(NREGS);
    localparam logic [7:0] OP_W    = 8'h57;
    localparam logic [7:0] OP_R    = 8'h52;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
`ifdef REGBRIDGE_CHECKSUM_EN
        GET_CSUM,
`endif
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            is_wr_q, is_wr_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      resp_q, resp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic [7:0]      regs_q [NREGS];
    logic [7:0]      regs_d [NREGS];
`ifdef REGBRIDGE_CHECKSUM_EN
    logic [7:0]      data_q, data_d;
`endif
    logic            acc;
    logic            in_get;
    logic [7:0]      byte_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            resp_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
`ifdef REGBRIDGE_CHECKSUM_EN
            data_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            regs_q    <= regs_d;
`ifdef REGBRIDGE_CHECKSUM_EN
            data_q    <= data_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        resp_d    = resp_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        regs_d    = regs_q;
`ifdef REGBRIDGE_CHECKSUM_EN
        data_d    = data_q;
`endif
        byte_in   = bus.out_data_i;
        acc       = bus.out_valid_i && (state_q != RESP);
        in_get    = (state_q != IDLE) && (state_q != RESP);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (acc) begin
                    if (byte_in == OP_W || byte_in == OP_R) begin
                        is_wr_d = (byte_in == OP_W);
                        state_d = GET_ADDR;
                    end else begin
                        resp_d  = NAK;
                        state_d = RESP;
                    end
                end
            end
            GET_ADDR: begin
                if (acc) begin
                    addr_d = byte_in;
                    if (is_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        state_d = RESP;
                        if ({1'b0, byte_in} < NREGS_W) resp_d = regs_q[byte_in[AW-1:0]];
                        else if (byte_in == 8'hFF)     resp_d = status_i;
                        else                           resp_d = NAK;
                    end
                end
            end
            GET_DATA: begin
                if (acc) begin
`ifdef REGBRIDGE_CHECKSUM_EN
                    data_d  = byte_in;
                    state_d = GET_CSUM;
`else
                    state_d = RESP;
                    resp_d  = NAK;
                    if ({1'b0, addr_q} < NREGS_W) begin
                        regs_d[addr_q[AW-1:0]] = byte_in;
                        resp_d = ACK;
                    end
`endif
                end
            end
`ifdef REGBRIDGE_CHECKSUM_EN
            GET_CSUM: begin
                if (acc) begin
                    state_d = RESP;
                    resp_d  = NAK;
                    if ({1'b0, addr_q} < NREGS_W && byte_in == (OP_W ^ addr_q ^ data_q)) begin
                        regs_d[addr_q[AW-1:0]] = data_q;
                        resp_d = ACK;
                    end
                end
            end
`endif
            RESP: begin
                if (bus.in_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte idle counter: saturating, abort to IDLE silently on expiry.
        if (in_get) begin
            if (acc) begin
                cnt_d = '0;
            end else begin
                if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
                if (TIMEOUT != 0 && cnt_d == CW'(TIMEOUT)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end
            end
        end
    end

    always_comb begin
        bus.out_ready_o = (state_q != RESP);
        bus.in_valid_o  = (state_q == RESP);
        bus.in_data_o   = resp_q;
        timeout_o       = timeout_q;
        regs_o          = '0;
        for (int k = 0; k < NREGS; k++) regs_o[8*k +: 8] = regs_q[k];
    end
endmodule

// File: doc/usb_cdc_regbridge.md
# usb_cdc_regbridge

Byte-stream register-access responder for the application side of the USB CDC device. It consumes the host→device byte stream (the CDC `out_*` handshake) and parses short commands from it: register writes, register reads and status reads. It returns one response byte per command on the device→host stream (the CDC `in_*` handshake). It sits between the CDC core and on-chip control logic, and exposes a small register file plus a status input to the host PC.

## Interface
Parameters:
- `NREGS`, 8: number of 8-bit registers, legal range 1..255; addresses `0..NREGS-1`.
- `TIMEOUT`, 48000: idle cycles allowed between bytes of one command (48000 = 1 ms at 48 MHz); 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `out_data_i` in 8: host→device byte from the CDC core.
- `out_valid_i` in 1: `out_data_i` is valid.
- `out_ready_o` out 1: bridge accepts a byte; transfer occurs when `out_valid_i & out_ready_o` at the edge.
- `in_data_o` out 8: response byte to the CDC core.
- `in_valid_o` out 1: response valid.
- `in_ready_i` in 1: CDC core accepts; transfer occurs when `in_valid_o & in_ready_i` at the edge.
- `status_i` in 8: status byte, readable at address 0xFF.
- `regs_o` out `NREGS*8`: register contents; reg k is at bits `[8k+7:8k]`.
- `timeout_o` out 1: one-cycle pulse when a partial command is aborted.

## Operation
- FSM states are IDLE, GET_ADDR, GET_DATA, GET_CSUM (only with the macro enabled) and RESP.
- `out_ready_o` = 1 in IDLE and all GET_* states; 0 in RESP. `in_valid_o` = 1 only in RESP.
- IDLE: accept an opcode byte.
  - 0x57 ('W') → GET_ADDR (write).
  - 0x52 ('R') → GET_ADDR (read).
  - Any other byte → RESP with 0x15 (NAK).
- GET_ADDR, read: accept the address byte, then go to RESP.
  - Address < NREGS → respond with reg value.
  - Address 0xFF → respond with `status_i`, sampled at the accept edge.
  - Otherwise → respond 0x15.
- GET_ADDR, write: accept the address byte → GET_DATA.
- GET_DATA (write): accept the data byte.
  - Address < NREGS → write the reg at this edge and respond 0x06 (ACK).
  - Otherwise (including 0xFF) → no write, respond 0x15.
- RESP: hold `in_data_o` and `in_valid_o` stable until `in_ready_i`; on the handshake edge → IDLE.
- Timeout:
  - The counter clears on every accepted byte and on entry to IDLE.
  - It increments each cycle spent in a GET_* state without a transfer.
  - Reaching `TIMEOUT` → IDLE, `timeout_o` pulses, no response, no write.
  - The counter width is `$clog2(TIMEOUT+1)` and it saturates (never wraps).
- Reset: state IDLE, all regs 0x00, `in_data_o` 0x00, `in_valid_o` 0, `timeout_o` 0, counter 0. `out_ready_o` is 1 from the first cycle after reset.
- Reset mid-command or mid-RESP discards the command and any pending response; no partial write occurs.

## Timing
- Response latency is 1 cycle: when the final byte is accepted at edge N, `in_valid_o` is high in the cycle following edge N.
- Register write and response load happen at the same edge; `regs_o` shows the new value in that following cycle.
- A read of a reg returns the value before any write of the same edge (no write can coincide with a read, since RESP blocks input).
- Back-to-back commands are allowed: the next opcode can be accepted in the cycle after the RESP handshake edge.
- Minimum round trip for a write is 3 byte cycles + 1 response cycle.

## Configuration
- `REGBRIDGE_CHECKSUM_EN` defined:
  - Write commands carry a 4th byte equal to `opcode ^ addr ^ data`, accepted in GET_CSUM.
  - The write happens only if the checksum matches and the address is valid; otherwise respond 0x15 with no write.
  - Timeout applies in GET_CSUM.
  - Read commands are unchanged.
- Undefined: GET_CSUM does not exist and writes are 3 bytes.

## Test plan
- Reset, then send 0x57 0x03 0xA5 (plus 0xF1 with checksum enabled) → response 0x06 one cycle after the last byte; `regs_o[31:24]` = 0xA5; then 0x52 0x03 → response 0xA5.
- Hold `in_ready_i` low 20 cycles during RESP → `in_valid_o` stays high, `in_data_o` stable, `out_ready_o` = 0 throughout; transfer completes on the first `in_ready_i` cycle.
- Send 0x52 0x08 with NREGS=8 → 0x15. Send 0x57 0x08 0x11 → 0x15 and all regs unchanged. Send 0x52 0xFF with `status_i`=0x3C → 0x3C. Send opcode 0x00 → 0x15.
- Send 0x57 0x01, then stall for TIMEOUT=16 cycles → `timeout_o` pulses once, no response; the next 0x52 0x01 returns 0x00.
- Assert `rst_n` low for one cycle after 0x57 0x02 is accepted → state IDLE, regs 0, `in_valid_o` 0; a subsequent full write completes normally.
- Checksum enabled: 0x57 0x02 0x10 with wrong checksum 0x00 → 0x15 and reg2 stays 0x00; correct checksum 0x45 → 0x06.
